// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with fixed 7-bit address, burst read/write, strobe-based local interface
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic        done_q, done_d, sda_oe_q, sda_oe_d;
  logic        rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, rw_q, rw_d;
  logic        addressed_q, addressed_d, start_det_q, start_det_d, stop_det_q, stop_det_d;
  logic        scl_s, scl_p, sda_s, sda_p, scl_rise, scl_fall, start_cond, stop_cond;

  // [0],[1] synchronise; [2] is the delayed copy used for edge detection
  assign scl_s      = scl_sync_q[1];
  assign scl_p      = scl_sync_q[2];
  assign sda_s      = sda_sync_q[1];
  assign sda_p      = sda_sync_q[2];
  assign scl_rise   = scl_s & ~scl_p;
  assign scl_fall   = ~scl_s & scl_p;
  assign start_cond = sda_p & ~sda_s & scl_s & scl_p;
  assign stop_cond  = ~sda_p & sda_s & scl_s & scl_p;

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign rw        = rw_q;
  assign addressed = addressed_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

  always_comb begin
    scl_sync_d  = {scl_sync_q[1:0], scl};
    sda_sync_d  = {sda_sync_q[1:0], sda};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = done_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    rw_d        = rw_q;
    addressed_d = addressed_q;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    if (start_cond) begin
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd7;
      addressed_d = 1'b0;
      start_det_d = 1'b1;
      done_d      = 1'b0;
      state_d     = ADDR;
    end else if (stop_cond) begin
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      stop_det_d  = 1'b1;
      done_d      = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) begin
              if (shift_q[6:0] == SLAVE_ADDR) begin
                rw_d   = sda_s;
                done_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            addressed_d = 1'b1;
            tx_req_d    = rw_q;
          end else if (scl_fall) begin
            bit_cnt_d = 3'd7;
            if (rw_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              state_d  = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == 3'd0) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else if (scl_fall && done_q) begin
            done_d   = 1'b0;
            sda_oe_d = 1'b1;
            state_d  = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && !done_q) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              done_d   = 1'b1;
            end else begin
              addressed_d = 1'b0;
              state_d     = IDLE;
            end
          end else if (scl_fall && done_q) begin
            done_d    = 1'b0;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 3'd7;
            state_d   = RD_DATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      done_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      rw_q        <= 1'b0;
      addressed_q <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      rw_q        <= rw_d;
      addressed_q <= addressed_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the team's I2C master on the same two-wire bus.
- Responds to one fixed 7-bit address and supports single-byte and burst writes and reads, including repeated START.
- Presents received bytes and requests transmit bytes over a simple strobe interface to local FPGA logic.
- Never stretches SCL. Only ever drives SDA low; otherwise SDA is released (high-Z).

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this block ACKs.

Ports:
clk  input  1  system clock; must be at least 20x the SCL frequency
reset_n  input  1  asynchronous active-low reset
scl  input  1  bus clock, sampled only, never driven
sda  inout  1  bus data; driven to 0 or high-Z only
rx_data  output  8  last byte written by the master
rx_valid  output  1  one-clk pulse when rx_data updates
tx_data  input  8  next byte to send to the master
tx_req  output  1  one-clk pulse requesting tx_data
rw  output  1  R/W bit of the current transaction (1 = read)
addressed  output  1  high from address ACK until STOP, repeated START or NACK
start_det  output  1  one-clk pulse per START or repeated START
stop_det  output  1  one-clk pulse per STOP

Behaviour:
- Reset (async, immediate): sda released; all outputs 0; state IDLE; bit_cnt 7.
- Synchronisation:
  - scl and sda each pass through a 2-flop synchroniser plus one delay flop for edge detect.
  - All bus events are seen 3 clk after the pin changes.
- Bus conditions:
  - START = synchronised sda falls while scl high. STOP = sda rises while scl high.
  - SCL rise = sample point. SCL fall = point where the slave changes its SDA drive.
- START in any state: release sda, bit_cnt=7, addressed=0, start_det pulse, go to ADDR.
- STOP in any state: release sda, addressed=0, stop_det pulse, go to IDLE.
- START/STOP detection takes priority over any SCL edge in the same clk.
- States:
  - IDLE: ignore SCL edges; wait for START.
  - ADDR: shift sda into an 8-bit register on each SCL rise, MSB first.
    - After the 8th rise: if bits[7:1]==SLAVE_ADDR, latch rw=bit0; on the next SCL fall drive sda low and go to ADDR_ACK.
    - On mismatch: go to IDLE with sda never driven.
  - ADDR_ACK:
    - At the SCL rise of the ACK slot: addressed=1; if rw=1, pulse tx_req.
    - At the following SCL fall: if rw=1, load tx_data into the shift register, drive its MSB (low→drive 0, high→release), go to RD_DATA. If rw=0, release sda and go to WR_DATA.
  - WR_DATA:
    - Sample on each SCL rise, bit_cnt 7→0.
    - After bit 0: rx_data updated and rx_valid pulsed in the same clk.
    - Next SCL fall: drive ACK (0), go to WR_ACK. Every data byte is ACKed.
  - WR_ACK: next SCL fall releases sda, bit_cnt=7, go to WR_DATA.
  - RD_DATA:
    - On each SCL fall, shift out the next bit.
    - On the SCL fall after bit 0, release sda and go to RD_ACK.
  - RD_ACK (sample master's ACK on SCL rise):
    - sda=0: pulse tx_req, stay in RD_ACK. Next SCL fall loads tx_data, drives its MSB, bit_cnt=7, go to RD_DATA.
    - sda=1 (NACK): addressed=0, sda stays released, go to IDLE.
- tx_data must be stable from the tx_req pulse until the next SCL fall (at least half an SCL period).
- STOP or repeated START mid-byte discards the partial byte; no rx_valid pulse.
- bit_cnt is 3 bits wide; 7 is reloaded at every byte boundary, with no wrap beyond 0.

Test Plan:
- Write 0x50+W, then byte 0xA5, then STOP → slave pulls SDA low in both ACK slots; rx_data=0xA5; exactly one rx_valid pulse; stop_det one pulse; addressed returns to 0.
- Address 0x51+W, then byte 0x12 → SDA never driven low by the slave; no rx_valid, no tx_req; addressed stays 0.
- Read 0x50+R with tx_data=0x3C, master ACK, then tx_data=0xC3, master NACK → bus bits 00111100 then 11000011; tx_req pulses twice; SDA released after the NACK; state IDLE.
- Write 0x50+W with byte 0x01, then repeated START, then 0x50+R, read 0x7E with NACK → rx_data=0x01; start_det pulses twice; rw switches 0→1; 0x7E appears on the bus.
- Write 0x50+W, then 4 data bits, then STOP → no rx_valid; rx_data unchanged; state IDLE; stop_det one pulse.
- reset_n asserted while the slave is driving a 0 bit during a read → sda high-Z in the same clk cycle; outputs return to 0; the next START is handled normally.
